chip8_fb_xor_engine: RTL and testbench
======================================

Name: chip8_fb_xor_engine

Overview:
Parametrised CHIP-8/SCHIP framebuffer with in-block sprite drawing.
- Accepts one sprite byte per handshake, XORs it into the stored row and reports pixel collision (VF semantics).
- Provides a multi-cycle clear (00E0), a registered byte-read port for the CPU, and a registered single-pixel scan port for the VGA emulator.
- Sits between the CPU core and the VGA emulator, replacing the plain byte-write framebuffer.

Parameters:
FB_W, 64, display width in pixels; power of two, 16..128 (128 for SCHIP hi-res).
FB_H, 32, display height in pixels; power of two, 8..64.
XW, $clog2(FB_W), column index width (derived, not overridden).
YW, $clog2(FB_H), row index width (derived, not overridden).

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
draw_valid  in  1  sprite byte request
draw_ready  out  1  engine can accept a request
draw_x  in  8  start column; taken modulo FB_W
draw_y  in  8  row; taken modulo FB_H
draw_data  in  8  sprite byte; bit 7 = leftmost pixel
draw_done  out  1  one-cycle pulse: draw committed
collision  out  1  1 if any set sprite bit hit a lit pixel; valid with draw_done
clear_req  in  1  clear entire framebuffer (single-cycle pulse, level tolerated)
clear_done  out  1  one-cycle pulse after last row cleared
rd_x  in  8  CPU read column, modulo FB_W
rd_y  in  8  CPU read row, modulo FB_H
rd_data  out  8  8 pixels from (rd_x, rd_y); bit 7 = column rd_x, wraps horizontally
scan_x  in  XW  VGA pixel column
scan_y  in  YW  VGA pixel row
scan_pixel  out  1  pixel at (scan_x, scan_y)

Behaviour:
- Storage: FB_H rows of FB_W flops. Reset asynchronously zeroes all pixels and all outputs.
- Ready on reset: draw_ready = (state == IDLE), so it reads 1 out of reset.
- FSM states:
  - IDLE: clear_req takes priority. If clear_req=1, go to CLEAR with row counter = 0. Else if draw_valid=1, latch x mod FB_W, y mod FB_H and data, then go to DRAW.
  - DRAW (1 cycle): mask = data placed at columns x..x+7. Set collision = |(row & mask), write row ^ mask, pulse draw_done with collision, return to IDLE.
  - CLEAR: zero one row per cycle. After row FB_H-1, pulse clear_done and return to IDLE. Total FB_H cycles after acceptance.
- Draw latency: request accepted at edge T; row updated, draw_done and collision valid in cycle T+1; draw_ready high again in cycle T+2.
- Back-to-back draws sustain 1 per 2 cycles.
- collision holds its value until the next draw_done. clear_done does not change it.
- clear_req or draw_valid outside IDLE is ignored; requesters must hold until accepted.
- Coordinates:
  - Start coordinates always wrap (x=70 with FB_W=64 gives column 6).
  - Columns past FB_W-1 are handled per the optional feature.
  - No vertical overflow: each request covers one row only.
- rd_data and scan_pixel are registered with 1-cycle latency.
- Reads in the same cycle as a DRAW/CLEAR row write return the pre-write value.
- Mid-operation reset: reset during DRAW or CLEAR aborts it. Array is zeroed, no done pulse, state IDLE.

Optional Feature:
CHIP8_FB_HWRAP_EN
- Defined: sprite bits whose column exceeds FB_W-1 wrap to column (x+i) mod FB_W, and they participate in collision.
- Undefined: those bits are clipped. They are not drawn and do not contribute to collision (CHIP-48 clipping behaviour).
- rd_data always wraps regardless of the macro.

Test Plan:
- Reset, then draw (0,0,0xF0): draw_done at T+1, collision=0; rd (0,0) reads 0xF0; scan (0..3,0)=1, (4,0)=0.
- Repeat the same draw: collision=1; rd (0,0) reads 0x00.
- Draw (60,5,0xFF). With CHIP8_FB_HWRAP_EN: columns 60-63 and 0-3 lit, rd (60,5)=0xFF. Without it: only 60-63 lit, rd (60,5)=0xF0, rd (0,5)=0x00.
- Draw (70,33,0x80) with FB_W=64, FB_H=32: pixel (6,1) lit. Then draw (6,1,0x01): collision=0.
- Fill several rows, assert clear_req and draw_valid together: clear wins, draw_ready low for exactly 32 cycles, clear_done pulses once, all rd reads 0x00. Then the held draw is accepted.
- Assert reset_n low during CLEAR row 10: no clear_done, draw_ready=1 after release, all pixels 0, collision=0.

Source files
------------

// File: rtl/chip8_fb_xor_engine.sv
// chip8_fb_xor_engine
// CHIP-8/SCHIP framebuffer with built-in sprite XOR drawing, multi-cycle
// clear, a registered CPU byte-read port and a registered VGA pixel port.
//
// Ports:
//   clk, reset_n             system clock, async active-low reset
//   draw_valid/draw_ready    sprite byte handshake (one byte = 8 pixels of a row)
//   draw_x, draw_y           start column / row, taken modulo FB_W / FB_H
//   draw_data                sprite byte, bit 7 = leftmost pixel
//   draw_done, collision     one-cycle commit pulse; collision held until next commit
//   clear_req, clear_done    clear whole framebuffer; pulse after last row
//   rd_x, rd_y, rd_data      CPU read of 8 pixels (bit 7 = column rd_x), wraps, 1-cycle latency
//   scan_x, scan_y,
//   scan_pixel               VGA single-pixel read, 1-cycle latency
//
// Build option:
//   CHIP8_FB_HWRAP_EN  defined   -> sprite bits past column FB_W-1 wrap to column 0..
//                      undefined -> those bits are clipped (no draw, no collision)
//
// state   | meaning
// S_IDLE  | ready; clear_req has priority over draw_valid
// S_DRAW  | one cycle: XOR mask into latched row, report collision
// S_CLEAR | zero one row per cycle, row 0 .. FB_H-1

module chip8_fb_xor_engine #(
  parameter int FB_W = 64,
  parameter int FB_H = 32,
  // derived widths; not meant to be overridden
  parameter int XW   = $clog2(FB_W),
  parameter int YW   = $clog2(FB_H)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          draw_valid,
  output logic          draw_ready,
  input  logic [7:0]    draw_x,
  input  logic [7:0]    draw_y,
  input  logic [7:0]    draw_data,
  output logic          draw_done,
  output logic          collision,
  input  logic          clear_req,
  output logic          clear_done,
  input  logic [7:0]    rd_x,
  input  logic [7:0]    rd_y,
  output logic [7:0]    rd_data,
  input  logic [XW-1:0] scan_x,
  input  logic [YW-1:0] scan_y,
  output logic          scan_pixel
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_CLEAR} state_t;

  state_t          r_state;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [YW-1:0]   r_row;
  logic [7:0]      r_data;
  logic [FB_W-1:0] r_fb [FB_H];
  logic            r_draw_done;
  logic            r_clear_done;
  logic            r_collision;
  logic [7:0]      r_rd_data;
  logic            r_scan_pixel;

  // Pixel column c is stored at bit c of a row; sprite bit 7 is column x, so
  // the byte is bit-reversed before being shifted into place.
  logic [7:0]        w_rev;
  logic [FB_W-1:0]   w_mask;
  logic [FB_W-1:0]   w_row_cur;
  logic [FB_W-1:0]   w_rd_row;
  logic [2*FB_W-1:0] w_rd_dbl;
  logic [7:0]        w_rd_byte;
  logic              w_unused;

  always_comb begin
    w_rev = '0;
    for (int i = 0; i < 8; i++) w_rev[i] = r_data[7-i];
  end

`ifdef CHIP8_FB_HWRAP_EN
  logic [2*FB_W-1:0] w_span;
  // Overflow lands in the upper half and is folded back onto column 0.
  assign w_span = {{(2*FB_W-8){1'b0}}, w_rev} << r_x;
  assign w_mask = w_span[FB_W-1:0] | w_span[2*FB_W-1:FB_W];
`else
  // Bits shifted past column FB_W-1 fall off the top: clipped.
  assign w_mask = {{(FB_W-8){1'b0}}, w_rev} << r_x;
`endif

  assign w_row_cur = r_fb[r_y];

  // Doubling the row makes the 8-pixel read window wrap horizontally.
  assign w_rd_row = r_fb[rd_y[YW-1:0]];
  assign w_rd_dbl = {w_rd_row, w_rd_row} >> rd_x[XW-1:0];

  always_comb begin
    w_rd_byte = '0;
    for (int i = 0; i < 8; i++) w_rd_byte[7-i] = w_rd_dbl[i];
  end

  // Coordinate bits above the index width are dropped by the modulo wrap.
  assign w_unused = ^{rd_x[7:XW], rd_y[7:YW], draw_x[7:XW], draw_y[7:YW],
                      w_rd_dbl[2*FB_W-1:8]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_row        <= '0;
      r_data       <= '0;
      r_draw_done  <= 1'b0;
      r_clear_done <= 1'b0;
      r_collision  <= 1'b0;
      r_rd_data    <= '0;
      r_scan_pixel <= 1'b0;
      for (int i = 0; i < FB_H; i++) r_fb[i] <= '0;
    end else begin
      r_draw_done  <= 1'b0;
      r_clear_done <= 1'b0;
      // Reads see the array before any row write of this same cycle.
      r_rd_data    <= w_rd_byte;
      r_scan_pixel <= r_fb[scan_y][scan_x];
      case (r_state)
        S_IDLE: begin
          if (clear_req) begin
            r_row   <= '0;
            r_state <= S_CLEAR;
          end else if (draw_valid) begin
            r_x     <= draw_x[XW-1:0];
            r_y     <= draw_y[YW-1:0];
            r_data  <= draw_data;
            r_state <= S_DRAW;
          end
        end
        S_DRAW: begin
          r_fb[r_y]   <= w_row_cur ^ w_mask;
          r_collision <= |(w_row_cur & w_mask);
          r_draw_done <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_CLEAR: begin
          r_fb[r_row] <= '0;
          if (r_row == YW'(FB_H - 1)) begin
            r_clear_done <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign draw_ready = (r_state == S_IDLE);
  assign draw_done  = r_draw_done;
  assign collision  = r_collision;
  assign clear_done = r_clear_done;
  assign rd_data    = r_rd_data;
  assign scan_pixel = r_scan_pixel;

endmodule

// File: tb/tb_chip8_fb_xor_engine.sv
module tb_chip8_fb_xor_engine;

  localparam int FB_W = 64;
  localparam int FB_H = 32;
  localparam int XW   = $clog2(FB_W);
  localparam int YW   = $clog2(FB_H);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          draw_valid = 1'b0;
  logic          draw_ready;
  logic [7:0]    draw_x = '0;
  logic [7:0]    draw_y = '0;
  logic [7:0]    draw_data = '0;
  logic          draw_done;
  logic          collision;
  logic          clear_req = 1'b0;
  logic          clear_done;
  logic [7:0]    rd_x = '0;
  logic [7:0]    rd_y = '0;
  logic [7:0]    rd_data;
  logic [XW-1:0] scan_x = '0;
  logic [YW-1:0] scan_y = '0;
  logic          scan_pixel;

  chip8_fb_xor_engine #(.FB_W(FB_W), .FB_H(FB_H)) dut (
    .clk(clk), .reset_n(reset_n),
    .draw_valid(draw_valid), .draw_ready(draw_ready),
    .draw_x(draw_x), .draw_y(draw_y), .draw_data(draw_data),
    .draw_done(draw_done), .collision(collision),
    .clear_req(clear_req), .clear_done(clear_done),
    .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .scan_x(scan_x), .scan_y(scan_y), .scan_pixel(scan_pixel)
  );

  always #10 clk = ~clk;

  typedef struct {
    string name;
    int    val;
    int    cyc;
  } exp_t;

  exp_t q_draw[$];
  exp_t q_clr[$];
  exp_t q_rd[$];
  exp_t q_scan[$];

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic rd_req = 1'b0, rd_pend = 1'b0;
  logic scan_req = 1'b0, scan_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rd_pend   <= rd_req;
    scan_pend <= scan_req;
  end

  // Monitor: pops an expectation whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (draw_done) begin
      if (q_draw.size() == 0) chk("unexpected draw_done", 1, 0);
      else begin
        e = q_draw.pop_front();
        chk({e.name, " collision"}, collision, e.val);
        chk({e.name, " done cycle"}, cyc, e.cyc);
      end
    end
    if (clear_done) begin
      if (q_clr.size() == 0) chk("unexpected clear_done", 1, 0);
      else begin
        e = q_clr.pop_front();
        chk({e.name, " done cycle"}, cyc, e.cyc);
      end
    end
    if (rd_pend) begin
      if (q_rd.size() == 0) chk("rd queue empty", 1, 0);
      else begin
        e = q_rd.pop_front();
        chk(e.name, rd_data, e.val);
      end
    end
    if (scan_pend) begin
      if (q_scan.size() == 0) chk("scan queue empty", 1, 0);
      else begin
        e = q_scan.pop_front();
        chk(e.name, scan_pixel, e.val);
      end
    end
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic do_draw(input int x, input int y, input int d, input int exp_coll,
                         input string name, output int acc_cyc);
    logic acc;
    draw_x = 8'(x); draw_y = 8'(y); draw_data = 8'(d); draw_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = draw_ready && !clear_req;
      @(posedge clk); #1;
    end
    draw_valid = 1'b0;
    acc_cyc = cyc;
    chk({name, " accepted"}, acc, 1);
    if (acc) q_draw.push_back('{name, exp_coll, cyc + 1});
    @(posedge clk); #1;
  endtask

  task automatic do_read(input int x, input int y, input int exp, input string name);
    rd_x = 8'(x); rd_y = 8'(y);
    q_rd.push_back('{name, exp, 0});
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic do_scan(input int x, input int y, input int exp, input string name);
    scan_x = XW'(x); scan_y = YW'(y);
    q_scan.push_back('{name, exp, 0});
    scan_req = 1'b1;
    @(posedge clk); #1;
    scan_req = 1'b0;
  endtask

  task automatic accept_clear(output logic acc, output int acc_cyc);
    clear_req = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = draw_ready;
      @(posedge clk); #1;
    end
    clear_req = 1'b0;
    acc_cyc = cyc;
    chk("clear accepted", acc, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_bad);
    $fatal(1);
  end

  initial begin
    int   a1, a2, ac;
    logic acc;

    repeat (3) @(posedge clk);
    #1;
    chk("reset draw_ready", draw_ready, 1);
    chk("reset collision", collision, 0);
    chk("reset draw_done", draw_done, 0);
    chk("reset clear_done", clear_done, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset scan_pixel", scan_pixel, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // basic draw / XOR erase
    do_draw(0, 0, 8'hF0, 0, "draw(0,0,F0)", a1);
    do_read(0, 0, 8'hF0, "rd(0,0) after draw");
    for (int i = 0; i < 4; i++) do_scan(i, 0, 1, $sformatf("scan(%0d,0)", i));
    do_scan(4, 0, 0, "scan(4,0)");
    do_draw(0, 0, 8'hF0, 1, "redraw(0,0,F0)", a1);
    do_read(0, 0, 8'h00, "rd(0,0) after erase");

    // right-edge overflow
    do_draw(60, 5, 8'hFF, 0, "draw(60,5,FF)", a1);
`ifdef CHIP8_FB_HWRAP_EN
    do_read(60, 5, 8'hFF, "rd(60,5) wrap");
    do_read(0, 5, 8'hF0, "rd(0,5) wrap");
`else
    do_read(60, 5, 8'hF0, "rd(60,5) clip");
    do_read(0, 5, 8'h00, "rd(0,5) clip");
`endif
    do_scan(63, 5, 1, "scan(63,5)");

    // start coordinates wrap
    do_draw(70, 33, 8'h80, 0, "draw(70,33,80)", a1);
    do_scan(6, 1, 1, "scan(6,1)");
    do_read(6, 1, 8'h80, "rd(6,1) after 70,33");
    do_draw(6, 1, 8'h01, 0, "draw(6,1,01)", a1);
    do_read(6, 1, 8'h81, "rd(6,1) after 01");
    do_draw(4, 1, 8'h20, 1, "draw(4,1,20) partial hit", a1);
    do_read(6, 1, 8'h01, "rd(6,1) after partial hit");

    // overflowed bits and collision; back-to-back throughput
    do_draw(0, 8, 8'hF0, 0, "draw(0,8,F0)", a1);
`ifdef CHIP8_FB_HWRAP_EN
    do_draw(60, 8, 8'h0F, 1, "draw(60,8,0F) wrap", a2);
    do_read(0, 8, 8'h00, "rd(0,8) wrap");
`else
    do_draw(60, 8, 8'h0F, 0, "draw(60,8,0F) clip", a2);
    do_read(0, 8, 8'hF0, "rd(0,8) clip");
`endif
    chk("back-to-back accept gap", a2 - a1, 2);

    // fill rows, then clear and draw requested together
    do_draw(10, 2, 8'hAA, 0, "draw(10,2,AA)", a1);
    do_draw(0, 31, 8'hFF, 0, "draw(0,31,FF)", a1);
    do_draw(5, 10, 8'h3C, 0, "draw(5,10,3C)", a1);
    draw_x = 8'd8; draw_y = 8'd3; draw_data = 8'h55; draw_valid = 1'b1;
    accept_clear(acc, ac);
    if (acc) q_clr.push_back('{"clear", 0, ac + FB_H});
    do_draw(8, 3, 8'h55, 0, "held draw(8,3,55)", a1);
    chk("held draw accept cycle", a1, ac + FB_H + 1);
    do_read(10, 2, 8'h00, "rd(10,2) cleared");
    do_read(0, 31, 8'h00, "rd(0,31) cleared");
    do_read(5, 10, 8'h00, "rd(5,10) cleared");
    do_read(6, 1, 8'h00, "rd(6,1) cleared");
    do_read(60, 5, 8'h00, "rd(60,5) cleared");
    do_read(0, 8, 8'h00, "rd(0,8) cleared");
    do_read(8, 3, 8'h55, "rd(8,3) held draw");

    // CPU read wraps horizontally and takes coordinates modulo size
    do_draw(0, 12, 8'h81, 0, "draw(0,12,81)", a1);
    do_read(60, 12, 8'h08, "rd(60,12) wrap");
    do_read(64, 44, 8'h81, "rd(64,44) modulo");
    do_scan(7, 12, 1, "scan(7,12)");

    // reset in the middle of a clear
    do_draw(0, 20, 8'hFF, 0, "draw(0,20,FF)", a1);
    do_draw(0, 20, 8'h80, 1, "draw(0,20,80)", a1);
    accept_clear(acc, ac);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #2;
    chk("mid-clear reset draw_ready", draw_ready, 1);
    chk("mid-clear reset collision", collision, 0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset draw_ready", draw_ready, 1);
    chk("post-reset collision", collision, 0);
    do_read(0, 20, 8'h00, "rd(0,20) after reset");
    do_read(0, 12, 8'h00, "rd(0,12) after reset");
    do_read(8, 3, 8'h00, "rd(8,3) after reset");
    repeat (FB_H + 10) @(posedge clk);
    #1;
    do_draw(0, 20, 8'h80, 0, "draw(0,20,80) after reset", a1);

    repeat (4) @(posedge clk);
    #1;
    chk("draw queue drained", q_draw.size(), 0);
    chk("clear queue drained", q_clr.size(), 0);
    chk("rd queue drained", q_rd.size(), 0);
    chk("scan queue drained", q_scan.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
